// File: rtl/oled_pkg.sv
// Shared opcode constants and arbiter FSM encoding for the OLED command path.
package oled_pkg;

  localparam logic [7:0] OP_IDLE  = 8'd0;
  localparam logic [7:0] OP_INIT  = 8'd1;
  localparam logic [7:0] OP_CLEAR = 8'd2;
  localparam logic [7:0] OP_CHAR  = 8'd3;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitStart,
    StWaitDone,
    StComplete
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from (last_grant + 1) mod NUM_REQ upward.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [1:0]         last_grant_i,
  output logic [1:0]         grant_o,
  output logic               grant_valid_o
);

  // Padded to four so a 2-bit index is always in range.
  logic [3:0] req_pad;
  logic [1:0] idx;

  assign req_pad = 4'(req_i);

  // First requesting index after the last grant wins.
  always_comb begin
    grant_o       = last_grant_i;
    grant_valid_o = 1'b0;
    idx           = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = 2'((32'(last_grant_i) + off) % NUM_REQ);
      if (!grant_valid_o && req_pad[idx]) begin
        grant_o       = idx;
        grant_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/oled_cmd_arbiter.sv
// Arbitrates several command requesters onto a single OLED driver, with a
// start/done handshake on drv_busy and a watchdog that aborts a stuck command.
module oled_cmd_arbiter
  import oled_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*8-1:0]    req_op,
  input  logic [NUM_REQ*16-1:0]   req_data,
  input  logic [NUM_REQ*16-1:0]   req_cursor,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      req_done,
  output logic [NUM_REQ-1:0]      req_error,
  output logic [7:0]              drv_op,
  output logic [15:0]             drv_data,
  output logic [7:0]              drv_cursor_x,
  output logic [7:0]              drv_cursor_y,
  input  logic                    drv_busy,
  output logic [1:0]              grant_id,
  output logic                    arb_busy
);

  arb_state_e  state_q, state_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [7:0]  drv_op_q, drv_op_d;
  logic [15:0] drv_data_q, drv_data_d;
  logic [7:0]  drv_x_q, drv_x_d;
  logic [7:0]  drv_y_q, drv_y_d;
  logic [31:0] wdog_q, wdog_d;

  logic [1:0]  rr_grant;
  logic        rr_valid;
  logic [7:0]  sel_op;
  logic [15:0] sel_data;
  logic [15:0] sel_cursor;
  logic        waiting;
  logic        timeout;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (rr_grant),
    .grant_valid_o(rr_valid)
  );

  assign waiting = (state_q == StWaitStart) || (state_q == StWaitDone);
  assign timeout = waiting && (wdog_q >= TIMEOUT_CYCLES);

  // Mux the winning requester's command fields.
  always_comb begin
    sel_op     = '0;
    sel_data   = '0;
    sel_cursor = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rr_grant == 2'(i)) begin
        sel_op     = req_op[8*i +: 8];
        sel_data   = req_data[16*i +: 16];
        sel_cursor = req_cursor[16*i +: 16];
      end
    end
  end

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a zero opcode bypasses the driver entirely.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (rr_valid) begin
          state_d = (sel_op == OP_IDLE) ? StComplete : StIssue;
        end
      end
      StIssue:     state_d = StWaitStart;
      StWaitStart: begin
        if (timeout) begin
          state_d = StIdle;
        end else if (drv_busy) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (timeout) begin
          state_d = StIdle;
        end else if (!drv_busy) begin
          state_d = StComplete;
        end
      end
      StComplete:  state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // Handshake pulses; suppressed while reset is held so an abort emits nothing.
  always_comb begin
    req_ready = '0;
    req_done  = '0;
    req_error = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = !reset && (state_q == StIdle) && rr_valid && (rr_grant == 2'(i));
      req_done[i]  = !reset && (state_q == StComplete) && (last_grant_q == 2'(i));
      req_error[i] = !reset && timeout && (last_grant_q == 2'(i));
    end
    arb_busy = (state_q != StIdle);
  end

  // Datapath next-state: grant memory, driver-facing command latch, watchdog.
  always_comb begin
    last_grant_d = last_grant_q;
    drv_op_d     = drv_op_q;
    drv_data_d   = drv_data_q;
    drv_x_d      = drv_x_q;
    drv_y_d      = drv_y_q;
    wdog_d       = wdog_q;
    unique case (state_q)
      StIdle: begin
        if (rr_valid) begin
          last_grant_d = rr_grant;
          // Loaded on the edge into ISSUE so the driver sees the command there.
          if (sel_op != OP_IDLE) begin
            drv_op_d   = sel_op;
            drv_data_d = sel_data;
            drv_x_d    = sel_cursor[7:0];
            drv_y_d    = sel_cursor[15:8];
          end
        end
      end
      StIssue: wdog_d = '0;
      StWaitStart, StWaitDone: begin
        wdog_d = wdog_q + 32'd1;
        if (timeout || (state_q == StWaitStart && drv_busy)) begin
          drv_op_d = OP_IDLE;
        end
      end
      StComplete: drv_op_d = OP_IDLE;
      default:    drv_op_d = OP_IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      last_grant_q <= 2'(NUM_REQ - 1);
      drv_op_q     <= '0;
      drv_data_q   <= '0;
      drv_x_q      <= '0;
      drv_y_q      <= '0;
      wdog_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      drv_op_q     <= drv_op_d;
      drv_data_q   <= drv_data_d;
      drv_x_q      <= drv_x_d;
      drv_y_q      <= drv_y_d;
      wdog_q       <= wdog_d;
    end
  end

  assign drv_op       = drv_op_q;
  assign drv_data     = drv_data_q;
  assign drv_cursor_x = drv_x_q;
  assign drv_cursor_y = drv_y_q;
  assign grant_id     = last_grant_q;

endmodule

// File: tb/tb_oled_cmd_arbiter.sv
// Scoreboard bench for oled_cmd_arbiter with a small reactive OLED driver model.
module tb_oled_cmd_arbiter;
  import oled_pkg::*;

  localparam int unsigned N   = 3;
  localparam int unsigned TMO = 50;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N*8-1:0]    req_op;
  logic [N*16-1:0]   req_data;
  logic [N*16-1:0]   req_cursor;
  logic [N-1:0]      req_ready, req_done, req_error;
  logic [7:0]        drv_op;
  logic [15:0]       drv_data;
  logic [7:0]        drv_cursor_x, drv_cursor_y;
  logic              drv_busy;
  logic [1:0]        grant_id;
  logic              arb_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          idx;
    logic [7:0]  op;
    logic [15:0] data;
    logic [15:0] cursor;
  } exp_t;

  exp_t exp_q[$];

  bit model_en   = 1'b1;
  int busy_width = 1;
  int busy_cnt   = 0;

  oled_cmd_arbiter #(
    .NUM_REQ       (N),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_data    (req_data),
    .req_cursor  (req_cursor),
    .req_ready   (req_ready),
    .req_done    (req_done),
    .req_error   (req_error),
    .drv_op      (drv_op),
    .drv_data    (drv_data),
    .drv_cursor_x(drv_cursor_x),
    .drv_cursor_y(drv_cursor_y),
    .drv_busy    (drv_busy),
    .grant_id    (grant_id),
    .arb_busy    (arb_busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Driver model: busy rises the cycle after a nonzero opcode appears, stays busy_width cycles.
  initial begin
    logic [7:0] s_op;
    logic       s_busy;
    logic       s_rst;
    drv_busy = 1'b0;
    forever begin
      @(negedge clk);
      s_op   = drv_op;
      s_busy = drv_busy;
      s_rst  = reset;
      @(posedge clk);
      #1;
      if (s_rst) begin
        drv_busy = 1'b0;
        busy_cnt = 0;
      end else if (s_busy) begin
        if (busy_cnt > 1) busy_cnt--;
        else begin
          drv_busy = 1'b0;
          busy_cnt = 0;
        end
      end else if (model_en && s_op != 8'd0) begin
        drv_busy = 1'b1;
        busy_cnt = busy_width;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout cyc=%0d want=finish", cyc);
    $fatal(1, "bench timeout");
  end

  task automatic set_req(input int i, input logic [7:0] op, input logic [15:0] data,
                         input logic [15:0] cur);
    req_op[8*i +: 8]      = op;
    req_data[16*i +: 16]  = data;
    req_cursor[16*i +: 16] = cur;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = '1;
    req_op    = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b want=000", req_ready); end
    total++; if (req_done !== 3'b000) begin bad++; $display("FAIL reset_done got=%b want=000", req_done); end
    total++; if (req_error !== 3'b000) begin bad++; $display("FAIL reset_error got=%b want=000", req_error); end
    total++; if (drv_op !== 8'd0) begin bad++; $display("FAIL reset_drv_op got=%0h want=0", drv_op); end
    total++; if (drv_data !== 16'd0) begin bad++; $display("FAIL reset_drv_data got=%0h want=0", drv_data); end
    total++; if ({drv_cursor_y, drv_cursor_x} !== 16'd0) begin bad++; $display("FAIL reset_cursor got=%0h want=0", {drv_cursor_y, drv_cursor_x}); end
    total++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL reset_arb_busy got=%b want=0", arb_busy); end
    total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL reset_grant_id got=%0d want=2", grant_id); end
    req_valid  = '0;
    req_op     = '0;
    req_data   = '0;
    req_cursor = '0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_single();
    exp_t e, got;
    logic [N-1:0] want;
    int c0;
    bit seen;
    @(negedge clk);
    set_req(0, OP_CLEAR, 16'h1234, 16'h0506);
    req_valid = 3'b001;
    e = '{idx: 0, op: OP_CLEAR, data: 16'h1234, cursor: 16'h0506};
    exp_q.push_back(e);
    #1;
    got  = exp_q.pop_front();
    want = N'(1) << got.idx;
    total++; if (req_ready !== want) begin bad++; $display("FAIL single_ready got=%b want=%b", req_ready, want); end
    c0 = cyc;
    @(posedge clk);
    #1 req_valid = '0;
    set_req(0, OP_INIT, 16'hFFFF, 16'hFFFF);
    @(negedge clk);
    total++; if (drv_op !== got.op) begin bad++; $display("FAIL single_issue_op got=%0h want=%0h", drv_op, got.op); end
    total++; if (drv_data !== got.data) begin bad++; $display("FAIL single_issue_data got=%0h want=%0h", drv_data, got.data); end
    total++; if (grant_id !== 2'(got.idx)) begin bad++; $display("FAIL single_grant_id got=%0d want=%0d", grant_id, got.idx); end
    @(negedge clk);
    total++; if (drv_op !== got.op) begin bad++; $display("FAIL single_hold_op got=%0h want=%0h", drv_op, got.op); end
    @(negedge clk);
    total++; if (drv_op !== 8'd0) begin bad++; $display("FAIL single_op_cleared got=%0h want=0", drv_op); end
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (req_done !== '0 || req_error !== '0) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (req_done !== want) begin bad++; $display("FAIL single_done got=%b want=%b", req_done, want); end
    total++; if (cyc - c0 !== 4) begin bad++; $display("FAIL single_latency got=%0d want=4 seen=%0d", cyc - c0, seen); end
    @(negedge clk);
    total++; if (req_done !== 3'b000) begin bad++; $display("FAIL single_done_width got=%b want=000", req_done); end
    total++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b want=0", arb_busy); end
  endtask

  task automatic test_zero_op();
    exp_t e, got;
    logic [N-1:0] want;
    int c0;
    @(negedge clk);
    set_req(1, OP_IDLE, 16'h00AA, 16'h0101);
    req_valid = 3'b010;
    e = '{idx: 1, op: OP_IDLE, data: 16'h00AA, cursor: 16'h0101};
    exp_q.push_back(e);
    #1;
    got  = exp_q.pop_front();
    want = N'(1) << got.idx;
    total++; if (req_ready !== want) begin bad++; $display("FAIL zero_ready got=%b want=%b", req_ready, want); end
    c0 = cyc;
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    total++; if (req_done !== want) begin bad++; $display("FAIL zero_done got=%b want=%b", req_done, want); end
    total++; if (cyc - c0 !== 1) begin bad++; $display("FAIL zero_latency got=%0d want=1", cyc - c0); end
    total++; if (drv_op !== 8'd0) begin bad++; $display("FAIL zero_drv_op got=%0h want=0", drv_op); end
    @(negedge clk);
    total++; if (drv_op !== 8'd0) begin bad++; $display("FAIL zero_drv_op_after got=%0h want=0", drv_op); end
    total++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL zero_idle got=%b want=0", arb_busy); end
  endtask

  task automatic test_contention();
    exp_t e, cur;
    logic [N-1:0] want;
    int order[4] = '{0, 1, 2, 0};
    int accepts, dones, pend;
    bit chk_issue;
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) set_req(i, OP_CHAR, 16'h0100 + 16'(i), 16'h0200 + 16'(i));
    for (int j = 0; j < 4; j++) begin
      e = '{idx: order[j], op: OP_CHAR, data: 16'h0100 + 16'(order[j]),
            cursor: 16'h0200 + 16'(order[j])};
      exp_q.push_back(e);
    end
    req_valid = 3'b111;
    accepts   = 0;
    dones     = 0;
    pend      = 0;
    chk_issue = 1'b0;
    cur       = e;
    for (int k = 0; k < 100 && dones < 4; k++) begin
      #1;
      if (chk_issue) begin
        chk_issue = 1'b0;
        total++; if (drv_data !== cur.data) begin bad++; $display("FAIL cont_issue_data got=%0h want=%0h", drv_data, cur.data); end
        total++; if (drv_op !== cur.op) begin bad++; $display("FAIL cont_issue_op got=%0h want=%0h", drv_op, cur.op); end
      end
      if (req_ready !== '0) begin
        if (exp_q.size() == 0) begin
          total++; bad++; $display("FAIL cont_extra_grant got=%b want=none", req_ready);
        end else begin
          cur  = exp_q.pop_front();
          want = N'(1) << cur.idx;
          total++; if (req_ready !== want) begin bad++; $display("FAIL cont_grant got=%b want=%b", req_ready, want); end
          accepts++;
          pend      = cur.idx;
          chk_issue = 1'b1;
        end
      end
      if (req_done !== '0) begin
        want = N'(1) << pend;
        total++; if (req_done !== want) begin bad++; $display("FAIL cont_done got=%b want=%b", req_done, want); end
        dones++;
        if (dones == 4) req_valid = '0;
      end
      @(negedge clk);
    end
    req_valid = '0;
    total++; if (accepts !== 4) begin bad++; $display("FAIL cont_accepts got=%0d want=4", accepts); end
    total++; if (dones !== 4) begin bad++; $display("FAIL cont_dones got=%0d want=4", dones); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL cont_queue got=%0d want=0", exp_q.size()); end
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    exp_t e, got;
    logic [N-1:0] want;
    int c0;
    bit seen;
    model_en = 1'b0;
    @(negedge clk);
    set_req(2, OP_INIT, 16'h0007, 16'h0000);
    req_valid = 3'b100;
    e = '{idx: 2, op: OP_INIT, data: 16'h0007, cursor: 16'h0000};
    exp_q.push_back(e);
    #1;
    got  = exp_q.pop_front();
    want = N'(1) << got.idx;
    total++; if (req_ready !== want) begin bad++; $display("FAIL tmo_ready got=%b want=%b", req_ready, want); end
    c0 = cyc;
    @(posedge clk);
    #1 req_valid = '0;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cyc == c0 + 30) begin
        total++; if (drv_op !== got.op) begin bad++; $display("FAIL tmo_hold_op got=%0h want=%0h", drv_op, got.op); end
      end
      if (req_done !== '0 || req_error !== '0) begin seen = 1'b1; break; end
    end
    total++; if (!seen) begin bad++; $display("FAIL tmo_no_event got=none want=error"); end
    total++; if (req_error !== want) begin bad++; $display("FAIL tmo_error got=%b want=%b", req_error, want); end
    total++; if (req_done !== 3'b000) begin bad++; $display("FAIL tmo_done got=%b want=000", req_done); end
    total++; if (cyc - c0 !== 2 + int'(TMO)) begin bad++; $display("FAIL tmo_latency got=%0d want=%0d", cyc - c0, 2 + TMO); end
    @(negedge clk);
    total++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL tmo_idle got=%b want=0", arb_busy); end
    total++; if (drv_op !== 8'd0) begin bad++; $display("FAIL tmo_drv_op got=%0h want=0", drv_op); end
    total++; if (req_error !== 3'b000) begin bad++; $display("FAIL tmo_error_width got=%b want=000", req_error); end
    model_en = 1'b1;
  endtask

  task automatic test_payload();
    exp_t e, got;
    logic [N-1:0] want;
    int c0;
    bit seen;
    @(negedge clk);
    set_req(0, 8'hA5, 16'h0422, 16'h0332);
    req_valid = 3'b001;
    e = '{idx: 0, op: 8'hA5, data: 16'h0422, cursor: 16'h0332};
    exp_q.push_back(e);
    #1;
    got  = exp_q.pop_front();
    want = N'(1) << got.idx;
    total++; if (req_ready !== want) begin bad++; $display("FAIL pay_ready got=%b want=%b", req_ready, want); end
    c0 = cyc;
    @(posedge clk);
    #1 req_valid = '0;
    set_req(0, 8'h11, 16'hBEEF, 16'h7788);
    @(negedge clk);
    total++; if (drv_op !== got.op) begin bad++; $display("FAIL pay_op_passthru got=%0h want=%0h", drv_op, got.op); end
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      total++; if (drv_data !== got.data) begin bad++; $display("FAIL pay_data got=%0h want=%0h", drv_data, got.data); end
      total++; if (drv_cursor_x !== got.cursor[7:0]) begin bad++; $display("FAIL pay_x got=%0h want=%0h", drv_cursor_x, got.cursor[7:0]); end
      total++; if (drv_cursor_y !== got.cursor[15:8]) begin bad++; $display("FAIL pay_y got=%0h want=%0h", drv_cursor_y, got.cursor[15:8]); end
      if (req_done !== '0) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (!seen || req_done !== want) begin bad++; $display("FAIL pay_done got=%b want=%b", req_done, want); end
    total++; if (cyc - c0 !== 4) begin bad++; $display("FAIL pay_latency got=%0d want=4", cyc - c0); end
  endtask

  task automatic test_mid_reset();
    exp_t e, got;
    logic [N-1:0] want;
    busy_width = 10;
    @(negedge clk);
    set_req(0, OP_INIT, 16'h0055, 16'h0102);
    req_valid = 3'b001;
    e = '{idx: 0, op: OP_INIT, data: 16'h0055, cursor: 16'h0102};
    exp_q.push_back(e);
    #1;
    got  = exp_q.pop_front();
    want = N'(1) << got.idx;
    total++; if (req_ready !== want) begin bad++; $display("FAIL mid_ready got=%b want=%b", req_ready, want); end
    @(posedge clk);
    #1 req_valid = '0;
    repeat (3) @(negedge clk);
    total++; if (arb_busy !== 1'b1) begin bad++; $display("FAIL mid_in_flight got=%b want=1", arb_busy); end
    reset = 1'b1;
    #1;
    total++; if (req_done !== 3'b000 || req_error !== 3'b000) begin bad++; $display("FAIL mid_abort_pulse got=%b/%b want=000/000", req_done, req_error); end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++; if (drv_op !== 8'd0) begin bad++; $display("FAIL mid_drv_op got=%0h want=0", drv_op); end
    total++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL mid_arb_busy got=%b want=0", arb_busy); end
    total++; if (req_done !== 3'b000 || req_error !== 3'b000) begin bad++; $display("FAIL mid_post_pulse got=%b/%b want=000/000", req_done, req_error); end
    busy_width = 1;
    for (int i = 0; i < 3; i++) set_req(i, OP_IDLE, 16'h0000, 16'h0000);
    req_valid = 3'b111;
    e = '{idx: 0, op: OP_IDLE, data: 16'h0000, cursor: 16'h0000};
    exp_q.push_back(e);
    #1;
    got  = exp_q.pop_front();
    want = N'(1) << got.idx;
    total++; if (req_ready !== want) begin bad++; $display("FAIL mid_regrant got=%b want=%b", req_ready, want); end
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    total++; if (req_done !== want) begin bad++; $display("FAIL mid_regrant_done got=%b want=%b", req_done, want); end
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_op     = '0;
    req_data   = '0;
    req_cursor = '0;
    test_reset();
    test_single();
    test_zero_op();
    test_contention();
    test_timeout();
    test_payload();
    test_mid_reset();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
